// File: rtl/si_dac_pkg.sv
// Shared constants, FSM encoding and parity helper for the multi-channel serial DAC loader.
// Optional per-channel even parity is enabled by defining SI_DAC_PARITY_EN.
package si_dac_pkg;

  localparam int DEF_WIDTH    = 12;
  localparam int DEF_CHANNELS = 4;

  // Widest channel word: 16 data bits plus one parity bit.
  localparam int PAR_W = 17;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } dac_state_e;

  // Zero extension does not change parity, so narrower words are passed widened.
  function automatic logic even_par_ok(input logic [PAR_W-1:0] word);
    return ~(^word);
  endfunction

endpackage

// File: rtl/si_dac_deser.sv
// Serial-in deserializer: bit/channel counters and per-channel staging shift registers.
// With SI_DAC_PARITY_EN each channel word carries a trailing even-parity bit.
module si_dac_deser
  import si_dac_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      SI,
  input  logic                      SI_en,
  output logic                      frame_done,
  output logic [CHANNELS*WIDTH-1:0] frame_data,
  output logic                      frame_perr
);

`ifdef SI_DAC_PARITY_EN
  localparam int WLEN = WIDTH + 1;
`else
  localparam int WLEN = WIDTH;
`endif
  localparam int BW = $clog2(WLEN);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WLEN - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);

  logic [BW-1:0]                  bit_cnt_r;
  logic [CW-1:0]                  ch_cnt_r;
  logic [CHANNELS-1:0][WLEN-1:0]  stage_r;
  logic [CHANNELS-1:0][WLEN-1:0]  stage_nxt_s;

  // Next staging contents, including the bit being captured this cycle.
  always_comb begin
    stage_nxt_s = stage_r;
    if (SI_en) begin
      stage_nxt_s[ch_cnt_r] = {stage_r[ch_cnt_r][WLEN-2:0], SI};
    end else begin
      stage_nxt_s = stage_r;
    end
  end

  assign frame_done = SI_en && (bit_cnt_r == BIT_LAST) && (ch_cnt_r == CH_LAST);

  // Frame view handed to the top on the completing edge, plus parity verdict.
  always_comb begin
    frame_data = '0;
    frame_perr = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      frame_data[k*WIDTH +: WIDTH] = stage_nxt_s[k][WLEN-1 -: WIDTH];
`ifdef SI_DAC_PARITY_EN
      if (!even_par_ok(PAR_W'(stage_nxt_s[k]))) begin
        frame_perr = 1'b1;
      end else begin
        frame_perr = frame_perr;
      end
`endif
    end
  end

  // Counters and staging advance only on enabled cycles; a pause holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r <= '0;
      ch_cnt_r  <= '0;
      stage_r   <= '0;
    end else if (SI_en) begin
      stage_r <= stage_nxt_s;
      if (bit_cnt_r == BIT_LAST) begin
        bit_cnt_r <= '0;
        if (ch_cnt_r == CH_LAST) begin
          ch_cnt_r <= '0;
        end else begin
          ch_cnt_r <= ch_cnt_r + CW'(1);
        end
      end else begin
        bit_cnt_r <= bit_cnt_r + BW'(1);
      end
    end
  end

endmodule

// File: rtl/si_dac_multi.sv
// Multi-channel serial DAC loader: holds a deserialized frame and applies it on a soc rising edge.
// Define SI_DAC_PARITY_EN to enable per-channel even parity with whole-frame rejection.
module si_dac_multi
  import si_dac_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      SI,
  input  logic                      SI_en,
  input  logic                      soc,
  output logic [CHANNELS*WIDTH-1:0] dac_code,
  output logic                      frame_ready,
  output logic                      load_done,
  output logic                      overrun,
  output logic                      parity_err
);

  localparam int FW = CHANNELS * WIDTH;

  logic           frame_done_s;
  logic           frame_perr_s;
  logic [FW-1:0]  frame_data_s;
  logic           soc_rise_s;
  logic           good_frame_s;

  logic [FW-1:0]  hold_r;
  logic [FW-1:0]  dac_code_r;
  dac_state_e     state_r;
  logic           frame_ready_r;
  logic           load_done_r;
  logic           overrun_r;
  logic           soc_d_r;

  si_dac_deser #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_deser (
    .clk        (clk),
    .rst        (rst),
    .SI         (SI),
    .SI_en      (SI_en),
    .frame_done (frame_done_s),
    .frame_data (frame_data_s),
    .frame_perr (frame_perr_s)
  );

  assign soc_rise_s   = soc & ~soc_d_r;
  assign good_frame_s = frame_done_s & ~frame_perr_s;

  // EMPTY/FULL hold FSM with soc edge detection and output flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r        <= '0;
      dac_code_r    <= '0;
      state_r       <= ST_EMPTY;
      frame_ready_r <= 1'b0;
      load_done_r   <= 1'b0;
      overrun_r     <= 1'b0;
      soc_d_r       <= 1'b1;
    end else begin
      soc_d_r     <= soc;
      load_done_r <= 1'b0;
      if (good_frame_s && soc_rise_s) begin
        // Completing frame bypasses hold and goes straight to the DAC.
        dac_code_r    <= frame_data_s;
        load_done_r   <= 1'b1;
        state_r       <= ST_EMPTY;
        frame_ready_r <= 1'b0;
      end else begin
        case (state_r)
          ST_EMPTY: begin
            if (good_frame_s) begin
              hold_r        <= frame_data_s;
              state_r       <= ST_FULL;
              frame_ready_r <= 1'b1;
            end
          end
          ST_FULL: begin
            if (good_frame_s) begin
              hold_r    <= frame_data_s;
              overrun_r <= 1'b1;
            end else if (soc_rise_s) begin
              dac_code_r    <= hold_r;
              load_done_r   <= 1'b1;
              state_r       <= ST_EMPTY;
              frame_ready_r <= 1'b0;
            end
          end
          default: begin
            state_r       <= ST_EMPTY;
            frame_ready_r <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SI_DAC_PARITY_EN
  logic parity_err_r;

  // Rejected-frame pulse, one cycle after the completing edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_r <= 1'b0;
    end else begin
      parity_err_r <= frame_done_s & frame_perr_s;
    end
  end

  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

  assign dac_code    = dac_code_r;
  assign frame_ready = frame_ready_r;
  assign load_done   = load_done_r;
  assign overrun     = overrun_r;

endmodule

// File: doc/si_dac_multi.md
SI_DAC_MULTI -- requirements
Module: si_dac_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 12, bits per channel code (range 4..16).
REQ-002 SHALL have parameter CHANNELS, default 4, number of DAC channels per serial frame (range 1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port SI  input  1  serial data bit, MSB first, channel 0 first.
REQ-006 SHALL have port SI_en  input  1  SI is sampled and shifted only when high.
REQ-007 SHALL have port soc  input  1  start of conversion; a rising edge requests a load of the held frame.
REQ-008 SHALL have port dac_code  output  CHANNELS*WIDTH  applied codes; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port frame_ready  output  1  a complete frame is held and not yet loaded.
REQ-010 SHALL have port load_done  output  1  one-cycle pulse when dac_code updates.
REQ-011 SHALL have port overrun  output  1  sticky flag: an unloaded held frame was overwritten.
REQ-012 SHALL have port parity_err  output  1  one-cycle pulse when a frame is rejected for parity.

Function
REQ-013 SHALL count bits (0..WLEN-1, WLEN=WIDTH, or WIDTH+1 with parity) and channels (0..CHANNELS-1); both advance only on cycles with SI_en=1.
REQ-014 SHALL hold the counters and partial data unchanged while SI_en=0 (pause, not abort).
REQ-015 SHALL shift SI into the staging word of the current channel, MSB first.
REQ-016 SHALL, on the edge capturing the last bit of channel CHANNELS-1, copy all staging words to the hold register, set frame_ready next cycle, and wrap both counters to 0.
REQ-017 SHALL detect soc rising as soc=1 with registered soc_d=0, soc_d reset to 1 so that soc held high out of reset is not an edge.
REQ-018 SHALL, on a soc rising edge with frame_ready=1, load hold into dac_code, clear frame_ready and pulse load_done, all visible after that same edge (latency 1 clk from soc sampled).
REQ-019 SHALL ignore a soc rising edge when frame_ready=0: dac_code unchanged, load_done stays 0.
REQ-020 SHALL, when frame completion and soc rising coincide, load the newly completed frame directly into dac_code, pulse load_done, leave frame_ready=0, and not set overrun.
REQ-021 SHALL, when a frame completes with frame_ready=1 and no coincident soc rising edge, overwrite hold, keep frame_ready=1 and set overrun until rst.
REQ-022 SHALL behave as a two-state FSM, EMPTY (frame_ready=0) and FULL (frame_ready=1), with transitions only per REQ-016..021.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, clear counters, staging, hold, dac_code, frame_ready, load_done, overrun and parity_err to 0 and set soc_d to 1.
REQ-024 SHALL discard any partial frame when rst asserts mid-frame; the next frame starts at channel 0, bit 0.

Configuration
REQ-025 SHALL support macro SI_DAC_PARITY_EN: when defined, each channel word is WIDTH data bits followed by one even-parity bit.
REQ-026 SHALL, with SI_DAC_PARITY_EN, flag any channel parity mismatch and at frame completion discard the whole frame (hold, frame_ready and overrun unchanged) and pulse parity_err.
REQ-027 SHALL, without SI_DAC_PARITY_EN, use WIDTH-bit words and drive parity_err constant 0, keeping the port.

Structure
REQ-028 SHALL place the default WIDTH/CHANNELS constants and FSM state encodings in the shared package si_dac_pkg.
REQ-029 SHALL use one sub-module, si_dac_deser, containing the bit/channel counters and staging shift logic; si_dac_multi holds the hold register, FSM, soc edge detection and flags.

Verification (WIDTH=12, CHANNELS=4, parity off unless stated)
REQ-030 SHALL test basic load: shift 48 bits coding 0x123,0x456,0x789,0xABC, then soc rising -> frame_ready=1 after the last bit; dac_code=0xABC789456123 and load_done for 1 cycle after the soc edge.
REQ-031 SHALL test pause: SI_en toggled randomly during a 48-bit frame -> identical dac_code to REQ-030; soc rising with no frame -> no load_done.
REQ-032 SHALL test overrun: two frames with no soc, then soc -> overrun=1 stays set, dac_code equals the second frame.
REQ-033 SHALL test coincidence: soc rising on the last-bit edge -> dac_code equals the new frame, frame_ready=0, overrun=0.
REQ-034 SHALL test reset mid-frame: rst after 20 bits, then a full frame -> dac_code equals the post-reset frame only, all flags 0 after rst.
REQ-035 SHALL, with SI_DAC_PARITY_EN, test bad parity: one bad parity bit in channel 2 -> parity_err pulse, frame_ready stays 0, dac_code unchanged.
